// File: rtl/io_stream_pkg.sv
// Shared widths and helpers for the GPIO pad stream <-> accelerator word path.
// Used by the input deserializer and the matching output serializer.
package io_stream_pkg;

  localparam int unsigned IO_DATA_WIDTH  = 16;
  localparam int unsigned ACC_WORD_WIDTH = 256;

  function automatic int unsigned beats_per_word(input int unsigned in_w,
                                                 input int unsigned out_w);
    return out_w / in_w;
  endfunction

endpackage

// File: rtl/io_stream_deserializer_if.sv
// Pad-side beat stream and core-side word stream of io_stream_deserializer.
// The flush signal exists only when DESER_FLUSH_EN is defined.
interface io_stream_deserializer_if import io_stream_pkg::*; #(
  parameter int unsigned IN_WIDTH  = IO_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH = ACC_WORD_WIDTH
);
  localparam int unsigned BEATS = beats_per_word(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned CNT_W = $clog2(BEATS);

  logic                 input_vld;
  logic                 input_rdy;
  logic [IN_WIDTH-1:0]  input_data;
  logic                 output_vld;
  logic                 output_rdy;
  logic [OUT_WIDTH-1:0] output_data;
  logic [CNT_W-1:0]     beat_cnt;
`ifdef DESER_FLUSH_EN
  logic                 flush;
`endif

  modport master (
    output input_vld, input_data, output_rdy,
`ifdef DESER_FLUSH_EN
    output flush,
`endif
    input  input_rdy, output_vld, output_data, beat_cnt
  );

  modport slave (
    input  input_vld, input_data, output_rdy,
`ifdef DESER_FLUSH_EN
    input  flush,
`endif
    output input_rdy, output_vld, output_data, beat_cnt
  );

endinterface

// File: rtl/io_stream_deserializer.sv
// Packs IN_WIDTH pad beats (first beat in LSBs) into OUT_WIDTH words with one assembly
// stage and one output register. Optional partial-word flush under DESER_FLUSH_EN.
module io_stream_deserializer import io_stream_pkg::*; #(
  parameter int unsigned IN_WIDTH  = IO_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH = ACC_WORD_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  io_stream_deserializer_if.slave bus
);
  localparam int unsigned BEATS = beats_per_word(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if ((OUT_WIDTH % IN_WIDTH) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("io_stream_deserializer: OUT_WIDTH must be a multiple of IN_WIDTH with >= 2 beats");
  end

  logic [OUT_WIDTH-1:0] asm_q, asm_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 asm_full_q, asm_full_d;
  logic                 out_vld_q, out_vld_d;
  logic                 beat_acc, word_acc, word_done;

  always_comb begin
    asm_d      = asm_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    asm_full_d = asm_full_q;
    out_vld_d  = out_vld_q;
    beat_acc   = bus.input_vld && !asm_full_q;
    word_acc   = out_vld_q && bus.output_rdy;

    if (beat_acc) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cnt_q == CNT_W'(i)) asm_d[i*IN_WIDTH +: IN_WIDTH] = bus.input_data;
      end
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
    word_done = beat_acc && (cnt_q == LAST_CNT);

`ifdef DESER_FLUSH_EN
    // Slices beyond the last written beat are still zero because the assembly
    // register is cleared whenever its word leaves.
    if (bus.flush && !asm_full_q && (beat_acc || cnt_q != '0)) begin
      word_done = 1'b1;
      cnt_d     = '0;
    end
`endif

    if (word_done) begin
      if (!out_vld_q || word_acc) begin
        out_data_d = asm_d;
        out_vld_d  = 1'b1;
        asm_d      = '0;
      end else begin
        asm_full_d = 1'b1;
      end
    end else if (word_acc) begin
      if (asm_full_q) begin
        out_data_d = asm_q;
        asm_d      = '0;
        asm_full_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      asm_full_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
      asm_full_q <= asm_full_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // input_rdy depends on a flop only, never on output_rdy.
  assign bus.input_rdy   = !asm_full_q;
  assign bus.output_vld  = out_vld_q;
  assign bus.output_data = out_data_q;
  assign bus.beat_cnt    = cnt_q;

endmodule
